// File: rtl/spi_cmd_log_if.sv
// iomem-style register bus between the picosoc (master) and spi_cmd_log (slave).
// ready is a single-cycle pulse; rdata is valid only while ready is high.
interface spi_cmd_log_if;
  logic        sel;
  logic [7:0]  addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output sel, addr, wstrb, wdata, input rdata, ready);
  modport slave  (input sel, addr, wstrb, wdata, output rdata, ready);
endinterface

// File: rtl/spi_cmd_log.sv
// Timestamped log of SPI commands seen by uspispy, buffered in a FIFO that the
// picosoc inspects and drains through a small iomem register window.
module spi_cmd_log #(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 16,
  parameter int TS_BITS  = 24
) (
  input  logic               clk_i,
  input  logic               resetn_i,
  input  logic               cmd_strobe_i,
  input  logic [7:0]         cmd_i,
  input  logic [31:0]        cmd_addr_i,
  input  logic [11:0]        cmd_len_i,
  spi_cmd_log_if.slave       bus,
  output logic               irq_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PSC_MAX    = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [7:0] ADDR_STATUS = 8'h00;
  localparam logic [7:0] ADDR_HEAD0  = 8'h04;
  localparam logic [7:0] ADDR_HEAD1  = 8'h08;
  localparam logic [7:0] ADDR_HEAD2  = 8'h0C;
  localparam logic [7:0] ADDR_POP    = 8'h10;

  typedef struct packed {
    logic [TS_BITS-1:0] ts;
    logic [7:0]         op;
    logic [31:0]        addr;
    logic [11:0]        len;
  } entry_t;

  entry_t mem_q [DEPTH];

  logic [PW-1:0]      psc_q, psc_d;
  logic [TS_BITS-1:0] ts_q, ts_d;
  logic               strobe_prev_q;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [15:0]        drops_q, drops_d;
  logic               ready_q;
  logic [31:0]        rdata_q, rdata_d;
  logic               irq_q;

  logic   psc_wrap, rise, access, is_write, empty, full;
  logic   push, pop, drop, clr;
  entry_t head, new_entry;
  logic   wdata_unused;

  // Write data is never interpreted: every writable register acts on the strobe alone.
  assign wdata_unused = ^bus.wdata;

  always_comb begin
    psc_wrap  = (psc_q == PSC_MAX);
    psc_d     = psc_wrap ? '0 : psc_q + 1'b1;
    ts_d      = psc_wrap ? ts_q + 1'b1 : ts_q;

    rise      = cmd_strobe_i & ~strobe_prev_q;
    access    = bus.sel & ~ready_q;
    is_write  = |bus.wstrb;
    empty     = (count_q == '0);
    full      = (count_q == FULL_COUNT);
    head      = mem_q[rd_ptr_q];

    new_entry.ts   = ts_q;
    new_entry.op   = cmd_i;
    new_entry.addr = cmd_addr_i;
    new_entry.len  = cmd_len_i;

    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    pop  = access & is_write & (bus.addr == ADDR_POP) & ~empty;
    clr  = access & is_write & (bus.addr == ADDR_STATUS);
    push = rise & (~full | pop);
    drop = rise & full & ~pop;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    drops_d = drops_q;
    if (clr) begin
      drops_d = drop ? 16'd1 : 16'd0;
    end else if (drop && (drops_q != 16'hFFFF)) begin
      drops_d = drops_q + 16'd1;
    end

    rdata_d = '0;
    if (access && !is_write) begin
      case (bus.addr)
        ADDR_STATUS: rdata_d = {drops_q, 7'b0, (drops_q != 16'd0), 8'(count_q)};
        ADDR_HEAD0:  rdata_d = empty ? 32'd0 : {24'(head.ts), head.op};
        ADDR_HEAD1:  rdata_d = empty ? 32'd0 : head.addr;
        ADDR_HEAD2:  rdata_d = empty ? 32'd0 : {20'd0, head.len};
        ADDR_POP:    rdata_d = 32'd0;
        default:     rdata_d = 32'hDECAFBAD;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      psc_q         <= '0;
      ts_q          <= '0;
      strobe_prev_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      drops_q       <= '0;
      ready_q       <= 1'b0;
      rdata_q       <= '0;
      irq_q         <= 1'b0;
    end else begin
      psc_q         <= psc_d;
      ts_q          <= ts_d;
      strobe_prev_q <= cmd_strobe_i;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      drops_q       <= drops_d;
      ready_q       <= access;
      rdata_q       <= rdata_d;
      irq_q         <= (count_d != '0);
    end
  end

  // Storage needs no reset: emptiness is tracked by count, and HEAD reads mask stale data.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign irq_o     = irq_q;

endmodule
